// File: rtl/ub_scheduler.sv
// Unified-buffer scheduler: arbitrates array load/store bursts and host
// byte writes onto a single-port buffer, streaming read bytes to the array.
module ub_scheduler #(
  parameter int BURST  = 4,
  parameter int ADDR_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_weight,
  input  logic                load_input,
  input  logic                store,
  input  logic [ADDR_W-1:0]   base_address,
  input  logic [8*BURST-1:0]  result_in,
  input  logic                host_wr_en,
  input  logic [ADDR_W-1:0]   host_addr,
  input  logic [7:0]          host_data,
  output logic                host_ready,
  output logic [ADDR_W-1:0]   ub_addr,
  output logic                ub_wr_en,
  output logic [7:0]          ub_wr_data,
  input  logic [7:0]          ub_rd_data,
  output logic [7:0]          weight_out,
  output logic                weight_valid,
  output logic [1:0]          weight_idx,
  output logic [7:0]          input_out,
  output logic                input_valid,
  output logic [1:0]          input_idx,
  output logic                busy
);

  localparam int              KW     = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(BURST - 1);

  typedef enum logic [1:0] {IDLE, RD, DRAIN, WR} state_t;
  state_t state, state_nx;

  logic              prev_w, prev_i, prev_s;
  logic              rise_w, rise_i, rise_s;
  logic              pend_w, pend_i, pend_s;
  logic [ADDR_W-1:0] addr_w, addr_i, addr_s;
  logic              gnt_w, gnt_i, gnt_s;

  logic [ADDR_W-1:0] base;
  logic [KW-1:0]     k;
  logic              op_w;       // current read burst feeds the weight stream
  logic [8*BURST-1:0] result_q;

  // one-cycle read return: valid/idx/stream select trail the issue by a cycle
  logic              rd_vld;
  logic [KW-1:0]     rd_idx;
  logic              rd_w;

  // Request edges and fixed-priority grants (store > weight > input)
  always_comb begin
    rise_w = load_weight & ~prev_w;
    rise_i = load_input  & ~prev_i;
    rise_s = store       & ~prev_s;
    gnt_s  = (state == IDLE) & pend_s;
    gnt_w  = (state == IDLE) & ~pend_s & pend_w;
    gnt_i  = (state == IDLE) & ~pend_s & ~pend_w & pend_i;
  end

  // Pending flags: a new edge always wins over a same-cycle grant clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_w <= 1'b0; prev_i <= 1'b0; prev_s <= 1'b0;
      pend_w <= 1'b0; pend_i <= 1'b0; pend_s <= 1'b0;
      addr_w <= '0;   addr_i <= '0;   addr_s <= '0;
    end else begin
      prev_w <= load_weight;
      prev_i <= load_input;
      prev_s <= store;
      pend_w <= (pend_w & ~gnt_w) | rise_w;
      pend_i <= (pend_i & ~gnt_i) | rise_i;
      pend_s <= (pend_s & ~gnt_s) | rise_s;
      if (rise_w) addr_w <= base_address;
      if (rise_i) addr_i <= base_address;
      if (rise_s) addr_s <= base_address;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: reads drain one extra cycle for the returning byte
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (gnt_s) state_nx = WR;
             else if (gnt_w || gnt_i) state_nx = RD;
      RD:    if (k == K_LAST) state_nx = DRAIN;
      DRAIN: state_nx = IDLE;
      WR:    if (k == K_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Burst context captured at grant, counter advanced while active
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base     <= '0;
      k        <= '0;
      op_w     <= 1'b0;
      result_q <= '0;
      rd_vld   <= 1'b0;
      rd_idx   <= '0;
      rd_w     <= 1'b0;
    end else begin
      if (gnt_s) begin
        base     <= addr_s;
        result_q <= result_in;
        k        <= '0;
      end else if (gnt_w) begin
        base <= addr_w;
        op_w <= 1'b1;
        k    <= '0;
      end else if (gnt_i) begin
        base <= addr_i;
        op_w <= 1'b0;
        k    <= '0;
      end else if (state == RD || state == WR) begin
        k <= k + KW'(1);
      end
      rd_vld <= (state == RD);
      rd_idx <= k;
      rd_w   <= op_w;
    end
  end

  // Buffer port mux: burst owns the port, host passes through only when idle
  always_comb begin
    host_ready = ~reset & (state == IDLE) & ~(pend_w | pend_i | pend_s)
                 & ~(rise_w | rise_i | rise_s);
    ub_addr    = '0;
    ub_wr_en   = 1'b0;
    ub_wr_data = '0;
    case (state)
      RD: ub_addr = base + ADDR_W'(k);
      WR: begin
        ub_addr    = base + ADDR_W'(k);
        ub_wr_en   = 1'b1;
        ub_wr_data = result_q[{k, 3'b000} +: 8];
      end
      IDLE: if (host_ready && host_wr_en) begin
        ub_addr    = host_addr;
        ub_wr_en   = 1'b1;
        ub_wr_data = host_data;
      end
      default: ;
    endcase
  end

  // Array streams: returning byte steered to the granted stream, zero otherwise
  always_comb begin
    weight_valid = rd_vld & rd_w;
    input_valid  = rd_vld & ~rd_w;
    weight_out   = weight_valid ? ub_rd_data : '0;
    weight_idx   = weight_valid ? 2'(rd_idx) : '0;
    input_out    = input_valid  ? ub_rd_data : '0;
    input_idx    = input_valid  ? 2'(rd_idx) : '0;
    busy         = (state != IDLE) | pend_w | pend_i | pend_s;
  end

endmodule

// File: tb/tb_ub_scheduler.sv
// Directed bench for ub_scheduler with a behavioural single-port buffer.
module tb_ub_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_weight, load_input, store;
  logic [4:0]  base_address;
  logic [31:0] result_in;
  logic        host_wr_en;
  logic [4:0]  host_addr;
  logic [7:0]  host_data;
  logic        host_ready;
  logic [4:0]  ub_addr;
  logic        ub_wr_en;
  logic [7:0]  ub_wr_data;
  logic [7:0]  ub_rd_data = 8'h00;
  logic [7:0]  weight_out, input_out;
  logic        weight_valid, input_valid;
  logic [1:0]  weight_idx, input_idx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:31];
  logic [7:0] sdat [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [4:0] sadr [4] = '{5'd30, 5'd31, 5'd0, 5'd1};

  ub_scheduler #(.BURST(4), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .load_weight(load_weight), .load_input(load_input), .store(store),
    .base_address(base_address), .result_in(result_in),
    .host_wr_en(host_wr_en), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready),
    .ub_addr(ub_addr), .ub_wr_en(ub_wr_en), .ub_wr_data(ub_wr_data),
    .ub_rd_data(ub_rd_data),
    .weight_out(weight_out), .weight_valid(weight_valid), .weight_idx(weight_idx),
    .input_out(input_out), .input_valid(input_valid), .input_idx(input_idx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // buffer model: synchronous write, one-cycle read latency
  always @(posedge clk) begin
    if (ub_wr_en) mem[ub_addr] <= ub_wr_data;
    ub_rd_data <= mem[ub_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; load_weight = 1'b0; load_input = 1'b0; store = 1'b0;
    base_address = '0; result_in = '0;
    host_wr_en = 1'b1; host_addr = 5'd3; host_data = 8'h77;
    tick(); tick(); smp();
    chk("rst_host_ready", host_ready, 0);
    chk("rst_ub_wr_en",   ub_wr_en, 0);
    chk("rst_ub_addr",    ub_addr, 0);
    chk("rst_busy",       busy, 0);
    chk("rst_wvalid",     weight_valid, 0);
    chk("rst_ivalid",     input_valid, 0);
    tick(); reset = 1'b0; host_wr_en = 1'b0; smp();
    chk("post_rst_host_ready", host_ready, 1);
    chk("post_rst_busy",       busy, 0);

    // host writes 0x11..0x14 to 4..7
    for (int i = 0; i < 4; i++) begin
      tick(); host_wr_en = 1'b1; host_addr = 5'(4 + i); host_data = 8'(8'h11 + i); smp();
      chk("host_ready",   host_ready, 1);
      chk("host_wr_en",   ub_wr_en, 1);
      chk("host_addr",    ub_addr, 4 + i);
      chk("host_wr_data", ub_wr_data, 8'h11 + i);
    end
    tick(); host_wr_en = 1'b0; smp();
    chk("host_idle_wr_en", ub_wr_en, 0);

    // weight load from base 4
    for (int c = 0; c <= 7; c++) begin
      tick();
      if (c == 0) begin load_weight = 1'b1; base_address = 5'd4; end
      if (c == 3) load_weight = 1'b0;
      smp();
      chk("w_valid", weight_valid, (c >= 3 && c <= 6));
      chk("w_ivalid", input_valid, 0);
      chk("w_busy", busy, (c >= 1 && c <= 6));
      if (c >= 3 && c <= 6) begin
        chk("w_data", weight_out, 8'h11 + c - 3);
        chk("w_idx",  weight_idx, c - 3);
      end
      if (c >= 2 && c <= 5) begin
        chk("w_rd_addr",  ub_addr, 4 + c - 2);
        chk("w_rd_wr_en", ub_wr_en, 0);
      end
      if (c == 0) chk("w_host_ready_edge", host_ready, 0);
      if (c == 7) chk("w_host_ready_done", host_ready, 1);
    end

    // store to base 30 with address wrap
    for (int c = 0; c <= 6; c++) begin
      tick();
      if (c == 0) begin store = 1'b1; base_address = 5'd30; result_in = 32'hDDCCBBAA; end
      if (c == 2) begin store = 1'b0; result_in = 32'h0BADF00D; end
      smp();
      chk("s_wr_en", ub_wr_en, (c >= 2 && c <= 5));
      chk("s_wvalid", weight_valid | input_valid, 0);
      if (c >= 2 && c <= 5) begin
        chk("s_addr", ub_addr, sadr[c-2]);
        chk("s_data", ub_wr_data, sdat[c-2]);
      end
      if (c == 6) chk("s_busy_done", busy, 0);
    end

    // simultaneous store/weight/input plus host write
    for (int c = 0; c <= 18; c++) begin
      tick();
      if (c == 0) begin
        store = 1'b1; load_weight = 1'b1; load_input = 1'b1;
        base_address = 5'd8; result_in = 32'h44332211;
        host_wr_en = 1'b1; host_addr = 5'd20; host_data = 8'h55;
      end
      if (c == 2) begin store = 1'b0; load_weight = 1'b0; load_input = 1'b0; end
      smp();
      chk("m_host_ready", host_ready, (c == 18));
      chk("m_wr_en", ub_wr_en, ((c >= 2 && c <= 5) || c == 18));
      chk("m_busy", busy, (c >= 1 && c <= 17));
      chk("m_wvalid", weight_valid, (c >= 8 && c <= 11));
      chk("m_ivalid", input_valid, (c >= 14 && c <= 17));
      if (c >= 2 && c <= 5) begin
        chk("m_st_addr", ub_addr, 8 + c - 2);
        chk("m_st_data", ub_wr_data, 8'h11 * (c - 1));
      end
      if (c >= 8 && c <= 11) begin
        chk("m_w_data", weight_out, 8'h11 * (c - 7));
        chk("m_w_idx",  weight_idx, c - 8);
      end
      if (c >= 14 && c <= 17) begin
        chk("m_i_data", input_out, 8'h11 * (c - 13));
        chk("m_i_idx",  input_idx, c - 14);
      end
      if (c == 18) begin
        chk("m_host_addr", ub_addr, 20);
        chk("m_host_data", ub_wr_data, 8'h55);
      end
    end
    tick(); host_wr_en = 1'b0;

    // input request arriving mid weight burst
    for (int c = 0; c <= 13; c++) begin
      tick();
      if (c == 0) begin load_weight = 1'b1; base_address = 5'd4; end
      if (c == 2) load_weight = 1'b0;
      if (c == 4) begin load_input = 1'b1; base_address = 5'd8; end
      if (c == 6) load_input = 1'b0;
      smp();
      chk("o_wvalid", weight_valid, (c >= 3 && c <= 6));
      chk("o_ivalid", input_valid, (c >= 9 && c <= 12));
      chk("o_overlap", weight_valid & input_valid, 0);
      if (c >= 3 && c <= 6) chk("o_w_data", weight_out, 8'h11 + c - 3);
      if (c >= 9 && c <= 12) begin
        chk("o_i_data", input_out, 8'h11 * (c - 8));
        chk("o_i_idx",  input_idx, c - 9);
      end
      if (c == 7)  chk("o_busy_pending", busy, 1);
      if (c == 13) chk("o_busy_done", busy, 0);
    end

    // reset mid read burst (k=2) with another request pending
    for (int c = 0; c <= 10; c++) begin
      tick();
      if (c == 0) begin load_input = 1'b1; base_address = 5'd4; end
      if (c == 2) begin load_weight = 1'b1; base_address = 5'd8; end
      if (c == 4) begin reset = 1'b1; load_input = 1'b0; load_weight = 1'b0; end
      if (c == 5) reset = 1'b0;
      smp();
      if (c == 3) begin
        chk("r_ivalid_pre", input_valid, 1);
        chk("r_idata_pre",  input_out, 8'h11);
      end
      if (c == 4) begin
        chk("r_rst_addr",  ub_addr, 0);
        chk("r_rst_wr_en", ub_wr_en, 0);
        chk("r_rst_hr",    host_ready, 0);
      end
      if (c >= 4) begin
        chk("r_ivalid", input_valid, 0);
        chk("r_wvalid", weight_valid, 0);
        chk("r_busy",   busy, 0);
      end
      if (c >= 5) chk("r_host_ready", host_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
